// File: rtl/chunk_arb_pkg.sv
// Shared types and constants for the two-source chunk arbiter.
package chunk_arb_pkg;

  localparam int DATA_WIDTH = 128;
  localparam int NUM_SRC    = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic                  id;
  } chunk_beat_t;

endpackage

// File: rtl/chunk_arbiter_skid_buffer.sv
// Two-entry AXIS register slice: registered ready, one-cycle latency, full throughput.
module axis_skid_buffer #(
  parameter int WIDTH = 130
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             push, pop;

  // Ready depends only on occupancy flops, never on m_ready.
  assign s_ready = (count_q != 2'd2);
  assign m_valid = (count_q != 2'd0);
  assign m_data  = head_q;

  assign push = s_valid && s_ready;
  assign pop  = m_valid && m_ready;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = s_data;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = s_data;
        end else if (push) begin
          tail_d  = s_data;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
      default: count_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/chunk_arbiter.sv
// Packet-granular round-robin arbiter of two AXIS chunk sources onto one skid-buffered output.
// Defining CHUNK_ARB_STATS_EN adds per-source completed-packet counters.
module chunk_arbiter #(
  parameter int DATA_WIDTH = chunk_arb_pkg::DATA_WIDTH,
  parameter int ID_WIDTH   = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  arb_en_in,
  input  logic                  s0_tvalid,
  output logic                  s0_tready,
  input  logic [DATA_WIDTH-1:0] s0_tdata,
  input  logic                  s0_tlast,
  input  logic                  s1_tvalid,
  output logic                  s1_tready,
  input  logic [DATA_WIDTH-1:0] s1_tdata,
  input  logic                  s1_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  output logic [ID_WIDTH-1:0]   m_tid,
  output logic                  grant_out,
  output logic                  busy_out
`ifdef CHUNK_ARB_STATS_EN
  ,
  output logic [15:0]           pkt_cnt0_out,
  output logic [15:0]           pkt_cnt1_out
`endif
);

  import chunk_arb_pkg::arb_state_t;
  import chunk_arb_pkg::ST_IDLE;
  import chunk_arb_pkg::ST_BUSY;
  import chunk_arb_pkg::NUM_SRC;

  localparam int BEAT_W = DATA_WIDTH + 1 + ID_WIDTH;

  arb_state_t            state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  last_served_q, last_served_d;
  logic [NUM_SRC-1:0]    s_valid, s_last, s_ready;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_valid, sel_last;
  logic                  skid_ready, beat_acc, busy;
  logic [BEAT_W-1:0]     skid_in, skid_out;

  assign s_valid   = {s1_tvalid, s0_tvalid};
  assign s_last    = {s1_tlast, s0_tlast};
  assign sel_valid = s_valid[grant_q];
  assign sel_last  = s_last[grant_q];
  assign sel_data  = grant_q ? s1_tdata : s0_tdata;
  assign busy      = (state_q == ST_BUSY);
  assign beat_acc  = busy && sel_valid && skid_ready;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= ST_IDLE;
      grant_q       <= 1'b0;
      last_served_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_served_q <= last_served_d;
    end
  end

  // Grants are only issued from idle, so a tlast always costs one bubble cycle.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_served_d = last_served_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_en_in && (|s_valid)) begin
          grant_d = (&s_valid) ? ~last_served_q : s_valid[1];
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (beat_acc && sel_last) begin
          last_served_d = grant_q;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      s_ready[i] = busy && (grant_q == 1'(i)) && skid_ready;
    end
  end

  assign s0_tready = s_ready[0];
  assign s1_tready = s_ready[1];
  assign busy_out  = busy;
  assign grant_out = grant_q;

  assign skid_in = {sel_data, sel_last, ID_WIDTH'(grant_q)};

  axis_skid_buffer #(
    .WIDTH (BEAT_W)
  ) u_skid (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .s_valid  (busy && sel_valid),
    .s_ready  (skid_ready),
    .s_data   (skid_in),
    .m_valid  (m_tvalid),
    .m_ready  (m_tready),
    .m_data   (skid_out)
  );

  assign m_tdata = skid_out[BEAT_W-1 -: DATA_WIDTH];
  assign m_tlast = skid_out[ID_WIDTH];
  assign m_tid   = skid_out[ID_WIDTH-1:0];

`ifdef CHUNK_ARB_STATS_EN
  logic [NUM_SRC-1:0][15:0] pkt_cnt;

  // Counts packets as they enter the skid buffer; wraps naturally at 16 bits.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cnt
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (beat_acc && sel_last && (grant_q == 1'(gi))) begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        cnt_q <= 16'd0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign pkt_cnt[gi] = cnt_q;
  end

  assign pkt_cnt0_out = pkt_cnt[0];
  assign pkt_cnt1_out = pkt_cnt[1];
`endif

endmodule
